// File: rtl/ray_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ray_pkg
//  Purpose  : Shared fixed-point types, state encoding and helpers for the
//             ray generator and its downstream hit-test consumers.
//  Revision : 1.0
// ============================================================================
package ray_pkg;

    localparam int D_BITS = 32;
    localparam int Q_BITS = 16;

    typedef logic signed [D_BITS-1:0] fixed_t;
    typedef fixed_t [2:0] vec3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } ray_gen_state_t;

    function automatic fixed_t int_to_fixed(input int v);
        return fixed_t'(v) <<< Q_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_scan_counter
//  Purpose  : Raster-order x/y counter with advance, clear and last-pixel flag.
//  Revision : 1.0
// ============================================================================
module pixel_scan_counter #(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int XY_BITS = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [XY_BITS-1:0] x,
    output logic [XY_BITS-1:0] y,
    output logic [XY_BITS-1:0] x_next,
    output logic [XY_BITS-1:0] y_next,
    output logic               last
);

    logic [XY_BITS-1:0] x_q;
    logic [XY_BITS-1:0] x_d;
    logic [XY_BITS-1:0] y_q;
    logic [XY_BITS-1:0] y_d;
    logic               w_x_end;
    logic               w_y_end;

    assign w_x_end = (x_q == XY_BITS'(WIDTH - 1));
    assign w_y_end = (y_q == XY_BITS'(HEIGHT - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (w_x_end) begin
                x_d = '0;
                y_d = w_y_end ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign x_next = x_d;
    assign y_next = y_d;
    assign last   = w_x_end && w_y_end;

endmodule
`default_nettype wire

// File: rtl/ray_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ray_gen
//  Purpose  : Camera ray generator; scans the pixel grid in raster order and
//             writes one fixed-point (origin, dir) ray per pixel downstream.
//  Revision : 1.0
// ============================================================================
module ray_gen
    import ray_pkg::*;
#(
    parameter int D_BITS  = 32,
    parameter int Q_BITS  = 16,
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter int FOCAL   = 16,
    parameter int XY_BITS = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0][D_BITS-1:0] cam_origin,
    output logic [2:0][D_BITS-1:0] origin,
    output logic [2:0][D_BITS-1:0] dir,
    output logic [XY_BITS-1:0]     pix_x,
    output logic [XY_BITS-1:0]     pix_y,
    output logic                   out_wr_en,
    input  logic                   out_full,
    output logic                   busy,
    output logic                   done
);

    localparam int    c_half_w    = WIDTH / 2;
    localparam int    c_half_h    = HEIGHT / 2;
    localparam int    c_max_mag   = (c_half_w > c_half_h) ?
                                    ((c_half_w > FOCAL) ? c_half_w : FOCAL) :
                                    ((c_half_h > FOCAL) ? c_half_h : FOCAL);
    localparam longint c_max_fixed = longint'(c_max_mag) <<< Q_BITS;
    localparam longint c_fixed_lim = 64'sd1 <<< (D_BITS - 1);
    localparam longint c_xy_lim    = 64'sd1 <<< XY_BITS;

    if (c_max_fixed >= c_fixed_lim) begin : g_range_check
        $error("ray_gen: largest direction component overflows D_BITS");
    end

    if ((longint'(WIDTH - 1) >= c_xy_lim) || (longint'(HEIGHT - 1) >= c_xy_lim)) begin : g_xy_check
        $error("ray_gen: XY_BITS too narrow for WIDTH/HEIGHT");
    end

    if ((WIDTH < 2) || (HEIGHT < 2) || (WIDTH % 2 != 0) || (HEIGHT % 2 != 0) || (FOCAL <= 0)) begin : g_geom_check
        $error("ray_gen: WIDTH/HEIGHT must be even and >= 2, FOCAL > 0");
    end

    ray_gen_state_t         state_q;
    ray_gen_state_t         state_d;
    logic [2:0][D_BITS-1:0] origin_q;
    logic [2:0][D_BITS-1:0] origin_d;
    logic [2:0][D_BITS-1:0] dir_q;
    logic [2:0][D_BITS-1:0] dir_d;

    logic                   w_scan_clear;
    logic                   w_scan_adv;
    logic                   w_scan_last;
    logic [XY_BITS-1:0]     w_x_next;
    logic [XY_BITS-1:0]     w_y_next;
    logic [D_BITS-1:0]      w_x_ext;
    logic [D_BITS-1:0]      w_y_ext;
    logic [2:0][D_BITS-1:0] w_dir_next;

    pixel_scan_counter #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .XY_BITS (XY_BITS)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_scan_clear),
        .advance (w_scan_adv),
        .x       (pix_x),
        .y       (pix_y),
        .x_next  (w_x_next),
        .y_next  (w_y_next),
        .last    (w_scan_last)
    );

    // Direction is derived from the counter's next value so it lands on the
    // same edge as the pixel coordinates it belongs to.
    assign w_x_ext       = D_BITS'(w_x_next);
    assign w_y_ext       = D_BITS'(w_y_next);
    assign w_dir_next[0] = (w_x_ext - D_BITS'(c_half_w)) << Q_BITS;
    assign w_dir_next[1] = (D_BITS'(c_half_h) - w_y_ext) << Q_BITS;
    assign w_dir_next[2] = D_BITS'(FOCAL) << Q_BITS;

    always_comb begin
        state_d      = state_q;
        origin_d     = origin_q;
        dir_d        = dir_q;
        w_scan_clear = 1'b0;
        w_scan_adv   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        out_wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    origin_d     = cam_origin;
                    w_scan_clear = 1'b1;
                    dir_d        = w_dir_next;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                busy      = 1'b1;
                out_wr_en = !out_full;
                if (!out_full) begin
                    if (w_scan_last) begin
                        w_scan_clear = 1'b1;
                        state_d      = DONE;
                    end else begin
                        w_scan_adv = 1'b1;
                        dir_d      = w_dir_next;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            origin_q <= '0;
            dir_q    <= '0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            dir_q    <= dir_d;
        end
    end

    assign origin = origin_q;
    assign dir    = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_ray_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ray_gen
//  Purpose  : Self-checking bench for ray_gen on a 4x4 grid with FOCAL=2.
//  Revision : 1.0
// ============================================================================
module tb_ray_gen;
    import ray_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int F = 2;
    localparam int BUDGET = 200;

    typedef struct {
        logic [15:0]       x;
        logic [15:0]       y;
        logic [2:0][31:0]  dir;
        logic [2:0][31:0]  org;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic [2:0][31:0]  cam_origin;
    logic [2:0][31:0]  origin;
    logic [2:0][31:0]  dir;
    logic [15:0]       pix_x;
    logic [15:0]       pix_y;
    logic              out_wr_en;
    logic              out_full;
    logic              busy;
    logic              done;

    int                checks;
    int                failures;
    int                wr_count;
    logic [2:0][31:0]  last_dir;
    exp_t              sb[$];

    ray_gen #(
        .D_BITS  (32),
        .Q_BITS  (16),
        .WIDTH   (W),
        .HEIGHT  (H),
        .FOCAL   (F),
        .XY_BITS (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cam_origin (cam_origin),
        .origin     (origin),
        .dir        (dir),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: every accepted write must match the next expected ray.
    always @(negedge clock) begin
        if (reset === 1'b1 && out_wr_en === 1'b1) begin
            exp_t e;
            wr_count++;
            last_dir = dir;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write pix=(%0d,%0d) dir=%h", pix_x, pix_y, dir);
            end else begin
                e = sb.pop_front();
                if ({pix_x, pix_y, dir, origin} !== {e.x, e.y, e.dir, e.org}) begin
                    failures++;
                    $display("FAIL ray_data got pix=(%0d,%0d) dir=%h org=%h want pix=(%0d,%0d) dir=%h org=%h",
                             pix_x, pix_y, dir, origin, e.x, e.y, e.dir, e.org);
                end
            end
        end
        if (reset === 1'b1 && done === 1'b1) begin
            checks++;
            if (out_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL done_overlap out_wr_en=%b want 0 while done", out_wr_en);
            end
        end
    end

    task automatic push_frame(input logic [2:0][31:0] org);
        exp_t e;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                e.x      = 16'(xx);
                e.y      = 16'(yy);
                e.dir[0] = int_to_fixed(xx - W / 2);
                e.dir[1] = int_to_fixed(H / 2 - yy);
                e.dir[2] = int_to_fixed(F);
                e.org    = org;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [2:0][31:0] org);
        @(posedge clock); #1;
        cam_origin = org;
        start      = 1'b1;
        wr_count   = 0;
        push_frame(org);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b0;
        out_full   = 1'b0;
        cam_origin = '0;
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (out_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", out_wr_en); end
        checks++;
        if ({origin, dir} !== '0) begin failures++; $display("FAIL reset_data got org=%h dir=%h want 0", origin, dir); end
        checks++;
        if ({pix_x, pix_y} !== 32'd0) begin failures++; $display("FAIL reset_pix got (%0d,%0d) want (0,0)", pix_x, pix_y); end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int n = 0;
        int first_n = 0;
        bit seen = 0;
        start_frame({32'hFFFB0000, 32'h0, 32'h0});
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start    = 1'b0;
            out_full = 1'b0;
            @(negedge clock); #1;
            n++;
            if (out_wr_en === 1'b1 && first_n == 0) first_n = n;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL basic_timeout no done within %0d cycles", BUDGET); end
        checks++;
        if (first_n != 1) begin failures++; $display("FAIL basic_first_latency got cycle %0d want 1", first_n); end
        checks++;
        if (n != 17) begin failures++; $display("FAIL basic_done_cycle got %0d want 17", n); end
        checks++;
        if (wr_count != 16 || sb.size() != 0) begin
            failures++; $display("FAIL basic_writes got %0d left=%0d want 16 left=0", wr_count, sb.size());
        end
        checks++;
        if (last_dir !== {32'h00020000, 32'hFFFF0000, 32'h00010000}) begin
            failures++; $display("FAIL basic_last_dir got %h want 00020000ffff000000010000", last_dir);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int stalled = 0;
        bit seen = 0;
        start_frame({32'h00030000, 32'h00020000, 32'h00010000});
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (wr_count == 6 && stalled < 5) begin
                out_full = 1'b1;
                stalled++;
            end else begin
                out_full = 1'b0;
            end
            @(negedge clock); #1;
            n++;
            if (out_full === 1'b1) begin
                checks++;
                if (out_wr_en !== 1'b0 || pix_x !== 16'd2 || pix_y !== 16'd1 ||
                    dir !== {32'h00020000, 32'h00010000, 32'h00000000}) begin
                    failures++;
                    $display("FAIL stall_hold got wr_en=%b pix=(%0d,%0d) dir=%h want 0 (2,1) 000200000001000000000000",
                             out_wr_en, pix_x, pix_y, dir);
                end
            end
            if (done === 1'b1) seen = 1;
        end
        out_full = 1'b0;
        checks++;
        if (!seen || n != 22) begin failures++; $display("FAIL stall_done_cycle got %0d want 22", n); end
        checks++;
        if (wr_count != 16 || sb.size() != 0) begin
            failures++; $display("FAIL stall_writes got %0d left=%0d want 16 left=0", wr_count, sb.size());
        end
    endtask

    task automatic test_ignored_start();
        int n = 0;
        bit pulsed = 0;
        bit seen = 0;
        start_frame({32'h00000000, 32'h00050000, 32'hFFFF0000});
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (wr_count == 3 && !pulsed) begin
                start      = 1'b1;
                cam_origin = {32'h12340000, 32'h56780000, 32'h9ABC0000};
                pulsed     = 1;
            end
            @(negedge clock); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        checks++;
        if (!seen || n != 17) begin failures++; $display("FAIL ignored_done_cycle got %0d want 17", n); end
        checks++;
        if (wr_count != 16 || sb.size() != 0) begin
            failures++; $display("FAIL ignored_writes got %0d left=%0d want 16 left=0", wr_count, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit seen = 0;
        start_frame({32'h00010000, 32'h00010000, 32'h00010000});
        for (int c = 0; c < BUDGET && wr_count < 9; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock); #1;
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock); #1;
        checks++;
        if ({origin, dir, pix_x, pix_y, busy, done, out_wr_en} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got org=%h dir=%h pix=(%0d,%0d) busy=%b done=%b wr=%b want all 0",
                     origin, dir, pix_x, pix_y, busy, done, out_wr_en);
        end
        checks++;
        if (wr_count != 9) begin failures++; $display("FAIL midreset_writes got %0d want 9", wr_count); end
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        start_frame({32'h00070000, 32'h0, 32'h0});
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 17 || wr_count != 16 || sb.size() != 0) begin
            failures++;
            $display("FAIL midreset_restart got cycles=%0d writes=%0d left=%0d want 17 16 0", n, wr_count, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        bit seen = 0;
        logic [2:0][31:0] org = {32'hFFFB0000, 32'h00000000, 32'h00000000};
        start_frame(org);
        for (int c = 0; c < BUDGET && wr_count < 16; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock); #1;
        end
        // Start is raised during DONE and held into IDLE; only the IDLE one counts.
        @(posedge clock); #1;
        start    = 1'b1;
        wr_count = 0;
        push_frame(org);
        @(negedge clock); #1;
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_pulse got %b want 1", done); end
        @(posedge clock); #1;
        @(negedge clock); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy, done);
        end
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start = 1'b0;
            @(negedge clock); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || n != 17 || wr_count != 16 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_second_frame got cycles=%0d writes=%0d left=%0d want 17 16 0", n, wr_count, sb.size());
        end
    endtask

    task automatic test_alternating();
        int n = 0;
        bit seen = 0;
        start_frame({32'h00000000, 32'hFFFF0000, 32'h00000000});
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(posedge clock); #1;
            start    = 1'b0;
            out_full = (c % 2 == 1);
            @(negedge clock); #1;
            n++;
            if (done === 1'b1) seen = 1;
        end
        out_full = 1'b0;
        checks++;
        if (!seen || n != 32) begin failures++; $display("FAIL alt_done_cycle got %0d want 32", n); end
        checks++;
        if (wr_count != 16 || sb.size() != 0) begin
            failures++; $display("FAIL alt_writes got %0d left=%0d want 16 left=0", wr_count, sb.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wr_count = 0;
        last_dir = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_alternating();
        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_gen.md
Name: ray_gen

Overview:
- Camera ray generator: the producer that feeds the p_hit input FIFO interface.
- On a start pulse it scans a WIDTH x HEIGHT pixel grid in raster order.
- For each pixel it emits one ray (origin, dir) in Q(D_BITS-Q_BITS).Q_BITS fixed point, using the in_wr_en/in_full write handshake that p_hit accepts.
- Per-pixel coordinates travel with each ray so downstream stages can tag hits.

Parameters:
- D_BITS, 32, fixed-point word width.
- Q_BITS, 16, fractional bits.
- WIDTH, 16, pixels per row; even, >= 2.
- HEIGHT, 16, rows per frame; even, >= 2.
- FOCAL, 16, image-plane distance in integer pixels; > 0.
- XY_BITS, 16, width of the pixel coordinate outputs; must hold WIDTH-1 and HEIGHT-1.

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle frame start request.
- cam_origin  in  3 x D_BITS signed  camera position, sampled on accepted start.
- origin  out  3 x D_BITS signed  ray origin for the current pixel.
- dir  out  3 x D_BITS signed  ray direction for the current pixel (unnormalised).
- pix_x  out  XY_BITS  column of the current ray.
- pix_y  out  XY_BITS  row of the current ray.
- out_wr_en  out  1  write strobe to downstream FIFO.
- out_full  in  1  downstream FIFO full.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last ray is written.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - origin, dir, pix_x, pix_y = 0.
  - busy=0, done=0, out_wr_en=0.
  - Reset mid-frame abandons the frame immediately; no further writes occur.
- States:
  - IDLE: busy=0. start==1 -> latch cam_origin into origin; x=y=0; go to EMIT.
  - EMIT: busy=1. out_wr_en = !out_full, combinational from out_full and state. Data ports are stable while EMIT holds.
  - DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Pixel advance in EMIT:
  - Occurs only on a cycle where out_wr_en==1 at posedge.
  - If x==WIDTH-1: x=0 and y=y+1. Otherwise x=x+1.
  - If x==WIDTH-1 and y==HEIGHT-1: go to DONE instead; counters are cleared.
- Backpressure: while out_full==1, out_wr_en=0 and counters, dir and origin hold unchanged. No ray is dropped or duplicated.
- Direction arithmetic (registered; updated on the same edge as the counters):
  - dir[0] = (x - WIDTH/2) << Q_BITS.
  - dir[1] = (HEIGHT/2 - y) << Q_BITS (screen-up is +y).
  - dir[2] = FOCAL << Q_BITS.
  - All signed, sign-extended to D_BITS.
  - Elaboration-time assertion: max(WIDTH/2, HEIGHT/2, FOCAL) << Q_BITS < 2^(D_BITS-1).
- pix_x/pix_y equal x/y of the ray currently presented.
- Latency: first out_wr_en can assert in the cycle after start is accepted. Throughput is 1 ray/cycle when out_full==0. An unstalled frame takes WIDTH*HEIGHT EMIT cycles plus 1 DONE cycle.
- start while not IDLE is ignored. start in the DONE cycle is ignored; a new frame needs start in IDLE.
- cam_origin changes during a frame are ignored.
- Total accepted writes per frame = WIDTH*HEIGHT exactly.

Decomposition:
- Shared package ray_pkg:
  - D_BITS, Q_BITS constants.
  - typedef vec3_t: 3 x signed D_BITS.
  - function int_to_fixed(int) returning signed D_BITS.
  - State enum ray_gen_state_t {IDLE, EMIT, DONE}.
  - These are reused by p_hit and its benches.
- One sub-module, pixel_scan_counter:
  - x/y raster counter with advance enable, clear, and last-pixel flag.
  - Parent holds the FSM and the dir/origin registers.

Test Plan:
- Basic frame. WIDTH=HEIGHT=4, FOCAL=2, cam_origin=(0,0,FFFB0000), start pulse, out_full=0:
  - 16 writes on consecutive cycles.
  - First write: dir=(FFFE0000, 00020000, 00020000), pix=(0,0).
  - Last write: dir=(00010000, FFFF0000, 00020000), pix=(3,3).
  - origin=(0,0,FFFB0000) on all writes.
  - done pulses one cycle after the 16th write.
- Backpressure. Hold out_full=1 for 5 cycles after write 6:
  - out_wr_en=0 throughout; pix holds (2,1) with dir=(00000000, 00010000, 00020000).
  - Resumes with no gap or repeat; total 16 writes; done 5 cycles later than the unstalled run.
- Ignored start/origin. Pulse start and change cam_origin at write 3:
  - Frame unaffected; 16 writes total; origin still the latched value.
- Reset mid-frame. Drive reset=0 at write 9:
  - Next cycle all outputs 0, busy=0.
  - A subsequent start restarts at pix (0,0) and produces 16 writes.
- Back-to-back frames. Pulse start in the IDLE cycle immediately after done:
  - Second frame produces identical data to the first; no overlap of done with writes.
- Alternating full. out_full toggles every cycle:
  - Exactly 16 writes, in raster order, with no duplicates.
